icache_refill_unit: RTL and testbench

//  Memory-side responder for the instruction cache. On a miss it fetches the missing 128-bit line

---
 rtl/icache_pkg.sv | 18 +
 rtl/icache_line_assembler.sv | 41 ++++
 rtl/icache_refill_unit.sv | 106 ++++++++++
 tb/tb_icache_refill_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared instruction-cache geometry and refill FSM state encoding.
// Used by both the cache array and the refill unit so line geometry stays consistent.
package icache_pkg;

    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
    localparam int OFFSET_BITS    = 4;
    localparam int INDEX_BITS     = 3;
    localparam int TAG_BITS       = 25;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_FILL = 2'd3;

endpackage

// File: rtl/icache_line_assembler.sv
// Line assembly buffer: one word written per cycle into a selected slot; o_line_nxt shows
// the buffer with this cycle's write already merged, so the final word can be captured same-edge.
module icache_line_assembler #(
    parameter int WORD_W = icache_pkg::WORD_W,
    parameter int WORDS  = icache_pkg::WORDS_PER_LINE,
    parameter int SLOT_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clr,
    input  logic                      i_we,
    input  logic [SLOT_W-1:0]         i_slot,
    input  logic [WORD_W-1:0]         i_wdat,
    output logic [WORD_W*WORDS-1:0]   o_line_nxt
);

    logic [WORD_W*WORDS-1:0] r_line;
    logic [WORD_W*WORDS-1:0] w_line_nxt;

    always_comb begin
        w_line_nxt = r_line;
        for (int k = 0; k < WORDS; k++) begin
            if (i_we && (i_slot == SLOT_W'(k))) begin
                w_line_nxt[k*WORD_W +: WORD_W] = i_wdat;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_line <= '0;
        end else if (i_clr) begin
            r_line <= '0;
        end else begin
            r_line <= w_line_nxt;
        end
    end

    assign o_line_nxt = w_line_nxt;

endmodule

// File: rtl/icache_refill_unit.sv
// I-cache miss refill: fetches a line word by word (one outstanding read, unbounded latency)
// and presents it with a one-cycle fill strobe; FILL lands 2*WORDS_PER_LINE+1 cycles after the miss at 1-cycle memory.
module icache_refill_unit #(
    parameter int ADDR_W         = icache_pkg::ADDR_W,
    parameter int WORD_W         = icache_pkg::WORD_W,
    parameter int WORDS_PER_LINE = icache_pkg::WORDS_PER_LINE
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             miss_req,
    input  logic [ADDR_W-1:0]                miss_addr,
    output logic                             busy,
    output logic                             mem_rd_en,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_rd_valid,
    input  logic [WORD_W-1:0]                mem_rd_data,
    output logic                             fill_valid,
    output logic [ADDR_W-1:0]                fill_addr,
    output logic [WORD_W*WORDS_PER_LINE-1:0] fill_line
);

    import icache_pkg::*;

    localparam int LW      = WORD_W * WORDS_PER_LINE;
    localparam int CW      = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int BYTE_SH = $clog2(WORD_W / 8);
    localparam int OFF_W   = $clog2(WORDS_PER_LINE * WORD_W / 8);
    localparam logic [CW-1:0]     LAST_SLOT = CW'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [LW-1:0]     r_fill_line;
    logic [LW-1:0]     w_line_nxt;
    logic              w_capture;
    logic              w_wr;

    assign w_capture = (r_state == ST_IDLE) && miss_req;
    assign w_wr      = (r_state == ST_WAIT) && mem_rd_valid;

    icache_line_assembler #(
        .WORD_W (WORD_W),
        .WORDS  (WORDS_PER_LINE),
        .SLOT_W (CW)
    ) u_asm (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_clr      (w_capture),
        .i_we       (w_wr),
        .i_slot     (r_cnt),
        .i_wdat     (mem_rd_data),
        .o_line_nxt (w_line_nxt)
    );

    // fill_line/fill_addr load on the edge entering FILL so they are valid alongside fill_valid
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_base      <= '0;
            r_fill_addr <= '0;
            r_fill_line <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (miss_req) begin
                        r_base  <= miss_addr & ~OFF_MASK;
                        r_cnt   <= '0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rd_valid) begin
                        if (r_cnt == LAST_SLOT) begin
                            r_fill_line <= w_line_nxt;
                            r_fill_addr <= r_base;
                            r_state     <= ST_FILL;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1);
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_FILL: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign mem_rd_en  = (r_state == ST_REQ);
    assign mem_addr   = r_base + (ADDR_W'(r_cnt) << BYTE_SH);
    assign fill_valid = (r_state == ST_FILL);
    assign fill_addr  = r_fill_addr;
    assign fill_line  = r_fill_line;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit: acts as the instruction memory and checks
// addresses, fill timing, line contents, busy and reset behaviour at each negedge.
module tb_icache_refill_unit;

    logic         CLK;
    logic         RST;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         busy;
    logic         mem_rd_en;
    logic [31:0]  mem_addr;
    logic         mem_rd_valid;
    logic [31:0]  mem_rd_data;
    logic         fill_valid;
    logic [31:0]  fill_addr;
    logic [127:0] fill_line;

    int n_checks = 0;
    int n_fail   = 0;

    icache_refill_unit dut (
        .CLK          (CLK),
        .RST          (RST),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .busy         (busy),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .fill_valid   (fill_valid),
        .fill_addr    (fill_addr),
        .fill_line    (fill_line)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one miss at the current negedge and serve memory reads; slow_k gets extra latency.
    task automatic refill(input logic [31:0] addr, input logic [31:0] dbase, input int slow_k,
                          input int extra, input bit spam, input int exp_fill, input int abort_k);
        logic [31:0]  base;
        logic [127:0] exp_line;
        int k_issued = 0;
        int k_pend   = 0;
        int k_got    = 0;
        int valid_at = -1;
        bit done     = 1'b0;
        bit aborted  = 1'b0;
        base     = {addr[31:4], 4'h0};
        exp_line = {dbase + 32'd3, dbase + 32'd2, dbase + 32'd1, dbase};
        miss_req  = 1'b1;
        miss_addr = addr;
        @(posedge CLK);
        for (int c = 1; c <= 60; c++) begin
            @(negedge CLK);
            if (abort_k >= 0 && k_got == abort_k + 1) begin
                mem_rd_valid = 1'b0;
                miss_req     = 1'b0;
                RST          = 1'b1;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_rd_en", mem_rd_en, 0);
                chk("abort_fill_valid", fill_valid, 0);
                chk("abort_fill_line", fill_line, 0);
                chk("abort_fill_addr", fill_addr, 0);
                chk("abort_mem_addr", mem_addr, 0);
                repeat (3) begin
                    @(negedge CLK);
                    chk("abort_no_fill", fill_valid, 0);
                end
                RST     = 1'b0;
                aborted = 1'b1;
                break;
            end
            miss_req = spam;
            if (spam) miss_addr = addr ^ (32'(c) << 8);
            mem_rd_valid = 1'b0;
            if (fill_valid) begin
                chk("fill_cycle", 32'(c), 32'(exp_fill));
                chk("fill_addr", fill_addr, base);
                chk("fill_line", fill_line, exp_line);
                chk("busy_in_fill", busy, 1);
                done = 1'b1;
            end else begin
                chk("busy", busy, 1);
            end
            if (valid_at != -1) chk("rd_en_in_wait", mem_rd_en, 0);
            if (mem_rd_en) begin
                chk("mem_addr", mem_addr, base + 32'(4 * k_issued));
                k_pend   = k_issued;
                k_issued = k_issued + 1;
                valid_at = c + 1 + ((k_pend == slow_k) ? extra : 0);
            end
            if (c == valid_at) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = dbase + 32'(k_pend);
                k_got        = k_got + 1;
                valid_at     = -1;
            end
            if (done) break;
        end
        if (!aborted) begin
            chk("fill_seen", done, 1);
            @(negedge CLK);
            mem_rd_valid = 1'b0;
            if (spam) begin
                miss_req  = 1'b1;
                miss_addr = 32'h0000_0500;
            end else begin
                miss_req = 1'b0;
            end
            chk("idle_after_fill", busy, 0);
            chk("fill_valid_one_cycle", fill_valid, 0);
            chk("fill_line_hold", fill_line, exp_line);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST          = 1'b1;
        miss_req     = 1'b0;
        miss_addr    = 32'h0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 32'h0;

        // 1: reset values, then idle with no miss
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_fill_addr", fill_addr, 0);
        chk("rst_fill_line", fill_line, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("idle_busy", busy, 0);
            chk("idle_rd_en", mem_rd_en, 0);
            chk("idle_fill_valid", fill_valid, 0);
        end

        // 2: basic refill, line-offset bits ignored
        refill(32'h0000_0048, 32'h0000_00A0, -1, 0, 1'b0, 9, -1);

        // 3: word 2 delayed by 5 extra cycles
        refill(32'h1234_5670, 32'h0000_00B0, 2, 5, 1'b0, 14, -1);

        // 5: reset after word 1 returns, then a fresh miss starts at word 0
        refill(32'h0000_0200, 32'h0000_0050, -1, 0, 1'b0, 9, 1);
        refill(32'h0000_0304, 32'h0000_0030, -1, 0, 1'b0, 9, -1);

        // 4: miss_req held high with changing addresses during the refill
        refill(32'h0000_0A08, 32'h0000_00C0, -1, 0, 1'b1, 9, -1);
        @(negedge CLK);
        chk("rearm_busy", busy, 1);
        chk("rearm_rd_en", mem_rd_en, 1);
        chk("rearm_mem_addr", mem_addr, 32'h0000_0500);
        miss_req = 1'b0;
        RST      = 1'b1;
        @(negedge CLK);
        RST = 1'b0;

        // 6: stray mem_rd_valid in IDLE, then top-of-address-space line
        @(negedge CLK);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hDEAD_BEEF;
        @(negedge CLK);
        mem_rd_valid = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_rd_en", mem_rd_en, 0);
        chk("stray_fill_valid", fill_valid, 0);
        chk("stray_fill_line", fill_line, 0);
        refill(32'hFFFF_FFF4, 32'h0000_0010, -1, 0, 1'b0, 9, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
